// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised vending controller with credit, refund, timeout and change return
// Optional per-item stock tracking is enabled by defining VEND_STOCK_EN.
module vend_ctrl_param #(
    parameter int                     N_ITEMS     = 5,
    parameter int                     MW          = 7,
    parameter int                     MAX_CREDIT  = 100,
    parameter logic [N_ITEMS*MW-1:0]  PRICE_TABLE = {7'd50, 7'd30, 7'd20, 7'd10, 7'd5},
    parameter int                     TIMEOUT_CYC = 1000,
    parameter int                     STOCK_W     = 4,
    parameter int                     STOCK_INIT  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       coin_valid_i,
    input  logic [MW-1:0]              coin_value_i,
    input  logic                       sel_valid_i,
    input  logic [$clog2(N_ITEMS)-1:0] sel_i,
    input  logic                       cancel_i,
`ifdef VEND_STOCK_EN
    input  logic                       restock_valid_i,
    input  logic [$clog2(N_ITEMS)-1:0] restock_sel_i,
    output logic                       sold_out_o,
`endif
    output logic [MW-1:0]              credit_o,
    output logic                       busy_o,
    output logic [N_ITEMS-1:0]         dispense_o,
    output logic [MW-1:0]              change_o,
    output logic                       change_valid_o,
    output logic                       coin_reject_o,
    output logic                       sel_error_o
);

    localparam int SW    = $clog2(N_ITEMS);
    localparam int SEL_N = 1 << SW;
    localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_REFUND} state_t;

    state_t             state_q, state_d;
    logic [MW-1:0]      credit_q, credit_d;
    logic [MW-1:0]      change_q, change_d;
    logic               change_valid_q, change_valid_d;
    logic [N_ITEMS-1:0] dispense_q, dispense_d;
    logic               coin_reject_q, coin_reject_d;
    logic               sel_error_q, sel_error_d;
    logic               busy_q, busy_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [MW-1:0]      price_w [SEL_N];
    logic [MW:0]        coin_sum;
    logic               coin_ok;
    logic               sel_ok;
    logic               do_refund;
`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [SEL_N];
    logic [STOCK_W-1:0] stock_d [SEL_N];
    logic               sold_out_q, sold_out_d;
`endif

    // Unused upper slots of the power-of-two table read as price 0; sel_ok keeps them unreachable.
    for (genvar g = 0; g < SEL_N; g++) begin : g_price
        if (g < N_ITEMS) begin : g_real
            assign price_w[g] = PRICE_TABLE[g*MW +: MW];
        end else begin : g_pad
            assign price_w[g] = '0;
        end
    end

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value_i};
    assign coin_ok  = ((coin_value_i == MW'(5)) || (coin_value_i == MW'(10)) ||
                       (coin_value_i == MW'(20)) || (coin_value_i == MW'(50))) &&
                      (coin_sum <= (MW+1)'(MAX_CREDIT));
    assign sel_ok   = (32'(sel_i) < N_ITEMS);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = '0;
        change_valid_d = 1'b0;
        dispense_d     = '0;
        coin_reject_d  = 1'b0;
        sel_error_d    = 1'b0;
        busy_d         = 1'b0;
        tmo_d          = '0;
        do_refund      = 1'b0;
`ifdef VEND_STOCK_EN
        stock_d        = stock_q;
        sold_out_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel_i && state_q == S_CREDIT) begin
                    do_refund     = 1'b1;
                    coin_reject_d = coin_valid_i;
                end else if (sel_valid_i) begin
                    coin_reject_d = coin_valid_i;
                    if (!sel_ok || credit_q < price_w[sel_i]) begin
                        sel_error_d = 1'b1;
`ifdef VEND_STOCK_EN
                    end else if (stock_q[sel_i] == '0) begin
                        sold_out_d = 1'b1;
`endif
                    end else begin
                        state_d        = S_VEND;
                        dispense_d     = N_ITEMS'(1) << sel_i;
                        change_d       = credit_q - price_w[sel_i];
                        change_valid_d = 1'b1;
                        busy_d         = 1'b1;
`ifdef VEND_STOCK_EN
                        stock_d[sel_i] = stock_q[sel_i] - 1'b1;
`endif
                    end
                end else if (coin_valid_i) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[MW-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (state_q == S_CREDIT && TIMEOUT_CYC != 0) begin
                    if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        do_refund = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            default: begin
                // VEND and REFUND last one cycle; credit is consumed on the way out.
                state_d       = S_IDLE;
                credit_d      = '0;
                coin_reject_d = coin_valid_i;
            end
        endcase
        if (do_refund) begin
            state_d        = S_REFUND;
            change_d       = credit_q;
            change_valid_d = 1'b1;
            busy_d         = 1'b1;
        end
`ifdef VEND_STOCK_EN
        if (restock_valid_i && 32'(restock_sel_i) < N_ITEMS) begin
            stock_d[restock_sel_i] = '1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            dispense_q     <= '0;
            coin_reject_q  <= 1'b0;
            sel_error_q    <= 1'b0;
            busy_q         <= 1'b0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            dispense_q     <= dispense_d;
            coin_reject_q  <= coin_reject_d;
            sel_error_q    <= sel_error_d;
            busy_q         <= busy_d;
            tmo_q          <= tmo_d;
        end
    end

`ifdef VEND_STOCK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SEL_N; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            sold_out_q <= 1'b0;
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out_o = sold_out_q;
`endif

    assign credit_o       = credit_q;
    assign busy_o         = busy_q;
    assign dispense_o     = dispense_q;
    assign change_o       = change_q;
    assign change_valid_o = change_valid_q;
    assign coin_reject_o  = coin_reject_q;
    assign sel_error_o    = sel_error_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - directed self-checking bench for vend_ctrl_param
module tb_vend_ctrl_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [6:0] coin_value;
    logic       sel_valid;
    logic [2:0] sel;
    logic       cancel;
    logic [6:0] credit;
    logic       busy;
    logic [4:0] dispense;
    logic [6:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       sel_error;
`ifdef VEND_STOCK_EN
    logic       restock_valid;
    logic [2:0] restock_sel;
    logic       sold_out;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vend_ctrl_param #(
        .TIMEOUT_CYC (8),
        .STOCK_INIT  (1)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .coin_valid_i   (coin_valid),
        .coin_value_i   (coin_value),
        .sel_valid_i    (sel_valid),
        .sel_i          (sel),
        .cancel_i       (cancel),
`ifdef VEND_STOCK_EN
        .restock_valid_i(restock_valid),
        .restock_sel_i  (restock_sel),
        .sold_out_o     (sold_out),
`endif
        .credit_o       (credit),
        .busy_o         (busy),
        .dispense_o     (dispense),
        .change_o       (change),
        .change_valid_o (change_valid),
        .coin_reject_o  (coin_reject),
        .sel_error_o    (sel_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [6:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic do_sel(input logic [2:0] s);
        sel_valid = 1'b1;
        sel       = s;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        coin_valid = 1'b0;
        coin_value = '0;
        sel_valid  = 1'b0;
        sel        = '0;
        cancel     = 1'b0;
`ifdef VEND_STOCK_EN
        restock_valid = 1'b0;
        restock_sel   = '0;
`endif
        step();
        step();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_change_valid", 32'(change_valid), 0);
        chk("rst_coin_reject", 32'(coin_reject), 0);
        chk("rst_sel_error", 32'(sel_error), 0);
        rst_n = 1'b1;
        step();

        // Exact-price vend: 10 + 10, item 2 costs 20
        put_coin(7'd10);
        chk("t1_credit10", 32'(credit), 10);
        put_coin(7'd10);
        chk("t1_credit20", 32'(credit), 20);
        do_sel(3'd2);
        chk("t1_dispense", 32'(dispense), 32'b00100);
        chk("t1_change", 32'(change), 0);
        chk("t1_change_valid", 32'(change_valid), 1);
        chk("t1_busy", 32'(busy), 1);
        step();
        chk("t1_credit_after", 32'(credit), 0);
        chk("t1_dispense_after", 32'(dispense), 0);
        chk("t1_busy_after", 32'(busy), 0);

        // Vend with change: 50 in, item 0 costs 5
        put_coin(7'd50);
        do_sel(3'd0);
        chk("t2_dispense", 32'(dispense), 32'b00001);
        chk("t2_change", 32'(change), 45);
        chk("t2_change_valid", 32'(change_valid), 1);
        step();
        chk("t2_credit_after", 32'(credit), 0);

        // Insufficient credit, then cancel refund
        put_coin(7'd5);
        do_sel(3'd4);
        chk("t3_sel_error", 32'(sel_error), 1);
        chk("t3_credit_kept", 32'(credit), 5);
        chk("t3_no_dispense", 32'(dispense), 0);
        step();
        chk("t3_sel_error_pulse", 32'(sel_error), 0);
        do_cancel();
        chk("t3_refund_change", 32'(change), 5);
        chk("t3_refund_valid", 32'(change_valid), 1);
        chk("t3_refund_busy", 32'(busy), 1);
        step();
        chk("t3_credit_after", 32'(credit), 0);
        chk("t3_busy_after", 32'(busy), 0);

        // Out-of-range index with ample credit
        put_coin(7'd50);
        do_sel(3'd5);
        chk("t3b_bad_index", 32'(sel_error), 1);
        chk("t3b_credit_kept", 32'(credit), 50);
        do_cancel();
        step();

        // Credit ceiling, illegal coin, simultaneous inputs
        put_coin(7'd50);
        put_coin(7'd50);
        chk("t4_credit100", 32'(credit), 100);
        put_coin(7'd5);
        chk("t4_overflow_reject", 32'(coin_reject), 1);
        chk("t4_overflow_credit", 32'(credit), 100);
        put_coin(7'd7);
        chk("t4_illegal_reject", 32'(coin_reject), 1);
        chk("t4_illegal_credit", 32'(credit), 100);
        cancel     = 1'b1;
        sel_valid  = 1'b1;
        sel        = 3'd0;
        coin_valid = 1'b1;
        coin_value = 7'd5;
        step();
        cancel     = 1'b0;
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        chk("t4_prio_change_valid", 32'(change_valid), 1);
        chk("t4_prio_change", 32'(change), 100);
        chk("t4_prio_coin_reject", 32'(coin_reject), 1);
        chk("t4_prio_no_dispense", 32'(dispense), 0);
        step();
        chk("t4_prio_credit_after", 32'(credit), 0);

        // Inactivity timeout (TIMEOUT_CYC = 8)
        put_coin(7'd20);
        repeat (7) step();
        chk("t5_pre_timeout_valid", 32'(change_valid), 0);
        chk("t5_pre_timeout_credit", 32'(credit), 20);
        step();
        chk("t5_timeout_valid", 32'(change_valid), 1);
        chk("t5_timeout_change", 32'(change), 20);
        step();
        chk("t5_credit_after", 32'(credit), 0);

        // Asynchronous reset in the middle of a vend
        put_coin(7'd20);
        do_sel(3'd2);
        chk("t6_vend_started", 32'(dispense), 32'b00100);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_dispense", 32'(dispense), 0);
        chk("t6_rst_credit", 32'(credit), 0);
        chk("t6_rst_change_valid", 32'(change_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_rst_dispense", 32'(dispense), 0);

`ifdef VEND_STOCK_EN
        // STOCK_INIT = 1: second vend of item 1 is sold out until restocked
        put_coin(7'd20);
        do_sel(3'd1);
        chk("t7_first_vend", 32'(dispense), 32'b00010);
        step();
        put_coin(7'd20);
        do_sel(3'd1);
        chk("t7_sold_out", 32'(sold_out), 1);
        chk("t7_no_dispense", 32'(dispense), 0);
        chk("t7_credit_kept", 32'(credit), 20);
        restock_valid = 1'b1;
        restock_sel   = 3'd1;
        step();
        restock_valid = 1'b0;
        do_sel(3'd1);
        chk("t7_restocked_vend", 32'(dispense), 32'b00010);
        chk("t7_restocked_change", 32'(change), 10);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
